// File: rtl/mem_lsu.sv
// Load/store initiator for a big-endian, byte-addressed data memory.
// Handles sub-word extension on loads and read-modify-write for SB/SH.
module mem_lsu #(
  parameter int unsigned MEMSIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_write,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, MERGE, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wword_q, wword_d;

  logic [31:0] aligned;
  logic [1:0]  size;
  logic [1:0]  off;
  logic        uns;
  logic        st;
  logic        err;
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [31:0] mask;
  logic [4:0]  sh;
  logic [31:0] merged;
  logic        wr;
  logic [31:0] wr_data;

  // Big-endian lanes: offset 0 sits in the top byte.
  always_comb begin
    aligned = {addr_q[31:2], 2'b00};
    size    = op_q[1:0];
    uns     = op_q[2];
    st      = op_q[3];
    off     = addr_q[1:0];
    err     = (size == 2'b11)
            | ((size == 2'b01) & off[0])
            | ((size == 2'b10) & (|off))
            | ((aligned + 32'd3) >= 32'(MEMSIZE));
    bsh     = {~off, 3'b000};
    hsh     = {~off[1], 4'b0000};
    lane_b  = 8'(mem_rdata >> bsh);
    lane_h  = 16'(mem_rdata >> hsh);
    ext     = mem_rdata;
    unique case (size)
      2'b00: ext = uns ? {24'b0, lane_b}
                       : {{24{lane_b[7]}}, lane_b};
      2'b01: ext = uns ? {16'b0, lane_h}
                       : {{16{lane_h[15]}}, lane_h};
      default: ext = mem_rdata;
    endcase
    mask    = (size == 2'b00) ? 32'h0000_00FF
                              : 32'h0000_FFFF;
    sh      = (size == 2'b00) ? bsh : hsh;
    merged  = (merge_q & ~(mask << sh))
            | ((wdata_q & mask) << sh);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr      = 1'b0;
    wr_data = wword_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = 32'b0;
        err_d   = 1'b0;
        state_d = RESP;
        if (err) begin
          err_d = 1'b1;
        end else if (!st) begin
          rdata_d = ext;
        end else if (size == 2'b10) begin
          wr      = 1'b1;
          wr_data = wdata_q;
        end else begin
          merge_d = mem_rdata;
          state_d = MERGE;
        end
      end
      MERGE: begin
        wr      = 1'b1;
        wr_data = merged;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    waddr_d = wr ? aligned : waddr_q;
    wword_d = wr ? wr_data : wword_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      merge_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
      waddr_q <= 32'b0;
      wword_q <= 32'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wword_q <= wword_d;
    end
  end

  // Outputs are forced quiet while reset is held, before the edge lands.
  assign req_ready  = rst_n & (state_q == IDLE);
  assign resp_valid = rst_n & (state_q == RESP);
  assign resp_rdata = rst_n ? rdata_q : 32'b0;
  assign resp_err   = rst_n & err_q;
  assign mem_raddr  = rst_n ? aligned : 32'b0;
  assign mem_write  = rst_n & wr;
  assign mem_waddr  = rst_n ? waddr_d : 32'b0;
  assign mem_wdata  = rst_n ? wword_d : 32'b0;

endmodule
